// File: rtl/swept_ram.sv
// swept_ram: single-port synchronous RAM with per-lane write enables,
// selectable read-during-write policy, optional output register and a
// hardware clear sweep that runs after every reset or on a clear pulse.
//
// Ports:
//   clk         clock, all logic on rising edge
//   rst_n       synchronous reset, active-low
//   address     entry to read or write
//   write_data  data to write
//   write_en    write request
//   byte_en     per-lane write mask (bit i covers [i*BYTE_W +: BYTE_W])
//   read_en     read request
//   clear       single-cycle request to start a clear sweep
//   read_data   registered read result
//   read_valid  one-cycle strobe when read_data carries a new result
//   busy        registered, high while the sweep runs
module swept_ram #(
  parameter int unsigned SIZE        = 16,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned BYTE_W      = 8,
  parameter int unsigned RDW_MODE    = 0,
  parameter int unsigned OUT_REG     = 0,
  parameter logic [SIZE-1:0] CLEAR_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [$clog2(DEPTH)-1:0]      address,
  input  logic [SIZE-1:0]               write_data,
  input  logic                          write_en,
  input  logic [SIZE/BYTE_W-1:0]        byte_en,
  input  logic                          read_en,
  input  logic                          clear,
  output logic [SIZE-1:0]               read_data,
  output logic                          read_valid,
  output logic                          busy
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LANES = SIZE / BYTE_W;

  typedef enum logic {SWEEP, READY} state_t;

  state_t            state;
  logic [AW-1:0]     ctr;
  logic [SIZE-1:0]   ram [DEPTH];
  logic [SIZE-1:0]   rd_data_q;
  logic              rd_valid_q;

  logic [SIZE-1:0]   old_word_c;
  logic [SIZE-1:0]   merged_word_c;
  logic [SIZE-1:0]   rd_word_c;
  logic              do_wr_c;
  logic              do_rd_c;

  // Access decode and lane merge; clear in READY overrides user traffic.
  always_comb begin
    old_word_c    = ram[address];
    merged_word_c = old_word_c;
    for (int i = 0; i < int'(LANES); i++) begin
      if (byte_en[i]) merged_word_c[i*BYTE_W +: BYTE_W] = write_data[i*BYTE_W +: BYTE_W];
    end
    do_wr_c   = (state == READY) && !clear && write_en;
    do_rd_c   = (state == READY) && !clear && read_en;
    // Write-first only sees merged data when a write actually happens.
    rd_word_c = (RDW_MODE == 1 && do_wr_c) ? merged_word_c : old_word_c;
  end

  // Storage: sweep writes the clear value, READY applies masked writes.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == SWEEP) ram[ctr] <= CLEAR_VALUE;
      else if (do_wr_c)   ram[address] <= merged_word_c;
    end
  end

  // Control FSM and first read stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SWEEP;
      ctr        <= '0;
      busy       <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= do_rd_c;
      if (do_rd_c) rd_data_q <= rd_word_c;
      case (state)
        SWEEP: begin
          if (ctr == AW'(DEPTH - 1)) begin
            state <= READY;
            busy  <= 1'b0;
          end else begin
            ctr <= ctr + AW'(1);
          end
        end
        READY: begin
          if (clear) begin
            state <= SWEEP;
            ctr   <= '0;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= SWEEP;
          ctr   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // Optional output pipeline stage; data holds unless a result arrives.
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [SIZE-1:0] out_data_q;
      logic            out_valid_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_data_q  <= '0;
          out_valid_q <= 1'b0;
        end else begin
          out_valid_q <= rd_valid_q;
          if (rd_valid_q) out_data_q <= rd_data_q;
        end
      end
      assign read_data  = out_data_q;
      assign read_valid = out_valid_q;
    end else begin : g_no_out_reg
      assign read_data  = rd_data_q;
      assign read_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_swept_ram.sv
// Directed bench: three instances share stimulus.
//   u0: read-first, no output register
//   u1: write-first, no output register
//   u2: read-first, output register
module tb_swept_ram;

  localparam logic [31:0] CV = 32'h5A5A5A5A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  address;
  logic [31:0] write_data;
  logic        write_en;
  logic [3:0]  byte_en;
  logic        read_en;
  logic        clear;
  logic [31:0] rd [3];
  logic        rv [3];
  logic        bz [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  swept_ram #(.SIZE(32), .DEPTH(16), .BYTE_W(8), .RDW_MODE(0), .OUT_REG(0), .CLEAR_VALUE(CV)) u0 (
    .clk(clk), .rst_n(rst_n), .address(address), .write_data(write_data), .write_en(write_en),
    .byte_en(byte_en), .read_en(read_en), .clear(clear),
    .read_data(rd[0]), .read_valid(rv[0]), .busy(bz[0]));
  swept_ram #(.SIZE(32), .DEPTH(16), .BYTE_W(8), .RDW_MODE(1), .OUT_REG(0), .CLEAR_VALUE(CV)) u1 (
    .clk(clk), .rst_n(rst_n), .address(address), .write_data(write_data), .write_en(write_en),
    .byte_en(byte_en), .read_en(read_en), .clear(clear),
    .read_data(rd[1]), .read_valid(rv[1]), .busy(bz[1]));
  swept_ram #(.SIZE(32), .DEPTH(16), .BYTE_W(8), .RDW_MODE(0), .OUT_REG(1), .CLEAR_VALUE(CV)) u2 (
    .clk(clk), .rst_n(rst_n), .address(address), .write_data(write_data), .write_en(write_en),
    .byte_en(byte_en), .read_en(read_en), .clear(clear),
    .read_data(rd[2]), .read_valid(rv[2]), .busy(bz[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a; write_data = d; byte_en = be; write_en = 1'b1;
    tick();
    write_en = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; address = '0; write_data = '0; write_en = 1'b0;
    byte_en = '0; read_en = 1'b0; clear = 1'b0;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rd[k] !== 32'h0 || rv[k] !== 1'b0 || bz[k] !== 1'b1) begin
        bad++;
        $display("FAIL reset_state u%0d: data=%h valid=%b busy=%b want 0/0/1", k, rd[k], rv[k], bz[k]);
      end
    end
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && bz[0] === 1'b1; c++) begin
      n++;
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (n != 16 || bz[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset_busy_len u%0d: cycles=%0d busy=%b want 16/0", k, n, bz[k]);
      end
    end
  endtask

  task automatic test_sweep_readback();
    for (int a = 0; a < 16; a++) begin
      address = 4'(a); read_en = 1'b1;
      tick();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (rv[k] !== 1'b1 || rd[k] !== CV) begin
          bad++;
          $display("FAIL sweep_read u%0d a=%0d: data=%h valid=%b want %h/1", k, a, rd[k], rv[k], CV);
        end
      end
      total++;
      if (rv[2] !== (a > 0) || (a > 0 && rd[2] !== CV)) begin
        bad++;
        $display("FAIL sweep_read_oreg a=%0d: data=%h valid=%b want %h/%0d", a, rd[2], rv[2], CV, a > 0);
      end
    end
    read_en = 1'b0;
    tick();
    total++;
    if (rv[0] !== 1'b0 || rv[2] !== 1'b1 || rd[2] !== CV) begin
      bad++;
      $display("FAIL sweep_read_tail: v0=%b v2=%b d2=%h want 0/1/%h", rv[0], rv[2], rd[2], CV);
    end
  endtask

  task automatic test_lanes();
    do_write(4'd3, 32'hAABBCCDD, 4'b1111);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (rv[k] !== 1'b0 || rd[k] !== CV) begin
        bad++;
        $display("FAIL write_holds_rd u%0d: data=%h valid=%b want %h/0", k, rd[k], rv[k], CV);
      end
    end
    do_write(4'd3, 32'h11223344, 4'b0101);
    do_write(4'd3, 32'h00000000, 4'b0000);
    address = 4'd3; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (rv[k] !== 1'b1 || rd[k] !== 32'hAA22CC44) begin
        bad++;
        $display("FAIL lane_merge u%0d: data=%h valid=%b want aa22cc44/1", k, rd[k], rv[k]);
      end
    end
    total++;
    if (rv[2] !== 1'b0) begin
      bad++;
      $display("FAIL oreg_early: valid=%b want 0", rv[2]);
    end
    tick();
    total++;
    if (rv[2] !== 1'b1 || rd[2] !== 32'hAA22CC44 || rv[0] !== 1'b0) begin
      bad++;
      $display("FAIL lane_merge_oreg: data=%h valid=%b v0=%b want aa22cc44/1/0", rd[2], rv[2], rv[0]);
    end
  endtask

  task automatic test_rdw();
    do_write(4'd5, 32'h00000000, 4'b1111);
    address = 4'd5; write_data = 32'hFFFF0000; byte_en = 4'b1100;
    write_en = 1'b1; read_en = 1'b1;
    tick();
    write_en = 1'b0; read_en = 1'b0;
    total++;
    if (rv[0] !== 1'b1 || rd[0] !== 32'h00000000) begin
      bad++;
      $display("FAIL rdw_read_first: data=%h valid=%b want 00000000/1", rd[0], rv[0]);
    end
    total++;
    if (rv[1] !== 1'b1 || rd[1] !== 32'hFFFF0000) begin
      bad++;
      $display("FAIL rdw_write_first: data=%h valid=%b want ffff0000/1", rd[1], rv[1]);
    end
    address = 4'd5; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    total++;
    if (rv[2] !== 1'b1 || rd[2] !== 32'h00000000) begin
      bad++;
      $display("FAIL rdw_oreg: data=%h valid=%b want 00000000/1", rd[2], rv[2]);
    end
    for (int k = 0; k < 2; k++) begin
      total++;
      if (rv[k] !== 1'b1 || rd[k] !== 32'hFFFF0000) begin
        bad++;
        $display("FAIL rdw_after u%0d: data=%h valid=%b want ffff0000/1", k, rd[k], rv[k]);
      end
    end
    tick();
    total++;
    if (rv[2] !== 1'b1 || rd[2] !== 32'hFFFF0000) begin
      bad++;
      $display("FAIL rdw_after_oreg: data=%h valid=%b want ffff0000/1", rd[2], rv[2]);
    end
  endtask

  task automatic test_busy_gating();
    int n;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    address = 4'd2; write_data = 32'h00001234; byte_en = 4'b1111;
    write_en = 1'b1; read_en = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && bz[0] === 1'b1; c++) begin
      n++;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (rv[k] !== 1'b0) begin
          bad++;
          $display("FAIL busy_gate_valid u%0d cyc=%0d: valid=%b want 0", k, c, rv[k]);
        end
      end
      tick();
    end
    write_en = 1'b0; read_en = 1'b0;
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL clear_busy_len: cycles=%0d want 16", n);
    end
    address = 4'd2; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (rv[k] !== 1'b1 || rd[k] !== CV) begin
        bad++;
        $display("FAIL busy_gate_data u%0d: data=%h valid=%b want %h/1", k, rd[k], rv[k], CV);
      end
    end
    tick();
  endtask

  task automatic test_clear_reset();
    int n;
    for (int a = 0; a < 16; a++) do_write(4'(a), 32'hC0DE0000 | 32'(a), 4'b1111);
    address = 4'd4; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    clear = 1'b1;
    total++;
    if (rv[0] !== 1'b1 || rd[0] !== 32'hC0DE0004) begin
      bad++;
      $display("FAIL fill_read: data=%h valid=%b want c0de0004/1", rd[0], rv[0]);
    end
    tick();
    clear = 1'b0;
    total++;
    if (rv[2] !== 1'b1 || rd[2] !== 32'hC0DE0004 || bz[0] !== 1'b1) begin
      bad++;
      $display("FAIL read_before_clear: d2=%h v2=%b busy=%b want c0de0004/1/1", rd[2], rv[2], bz[0]);
    end
    for (int c = 0; c < 6; c++) tick();
    rst_n = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rd[k] !== 32'h0 || rv[k] !== 1'b0 || bz[k] !== 1'b1) begin
        bad++;
        $display("FAIL midsweep_reset u%0d: data=%h valid=%b busy=%b want 0/0/1", k, rd[k], rv[k], bz[k]);
      end
    end
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && bz[0] === 1'b1; c++) begin
      n++;
      tick();
    end
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL restart_busy_len: cycles=%0d want 16", n);
    end
    for (int a = 0; a < 16; a++) begin
      address = 4'(a); read_en = 1'b1;
      tick();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (rv[k] !== 1'b1 || rd[k] !== CV) begin
          bad++;
          $display("FAIL restart_read u%0d a=%0d: data=%h valid=%b want %h/1", k, a, rd[k], rv[k], CV);
        end
      end
    end
    read_en = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sweep_readback();
    test_lanes();
    test_rdw();
    test_busy_gating();
    test_clear_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
